// File: rtl/conv3x3_window_gen.sv
// conv3x3_window_gen: builds 3x3 sliding windows from a raster pixel stream
// using two line buffers, sequences the downstream MAC through steps 0..9 and
// captures its saturated result. Only fully populated (unpadded) windows are
// emitted: (IMG_W-2)*(IMG_H-2) per frame.
module conv3x3_window_gen #(
    parameter int IMG_W = 8,
    parameter int IMG_H = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] pix_in,
    input  logic       pix_valid,
    output logic       pix_ready,
    output logic [7:0] win0,
    output logic [7:0] win1,
    output logic [7:0] win2,
    output logic [7:0] win3,
    output logic [7:0] win4,
    output logic [7:0] win5,
    output logic [7:0] win6,
    output logic [7:0] win7,
    output logic [7:0] win8,
    output logic [3:0] cnt,
    input  logic [7:0] ans,
    output logic [7:0] res_data,
    output logic       res_valid,
    output logic       frame_done
);

    localparam int CW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam int RW = (IMG_H > 1) ? $clog2(IMG_H) : 1;
    localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);
    localparam logic [CW-1:0] COL_TWO  = CW'(2);
    localparam logic [RW-1:0] ROW_TWO  = RW'(2);
    localparam logic [3:0]    CNT_IDLE = 4'd15;
    localparam logic [3:0]    CNT_LAST = 4'd9;

    typedef enum logic {
        S_FILL    = 1'b0,
        S_COMPUTE = 1'b1
    } state_t;

    state_t        r_state;
    state_t        w_state_nxt;
    logic [3:0]    r_cnt;
    logic [3:0]    w_cnt_nxt;
    logic [CW-1:0] r_col;
    logic [RW-1:0] r_row;

    // Line buffers: lb0 holds row r-1, lb1 holds row r-2, indexed by column.
    logic [7:0]    r_lb0 [IMG_W];
    logic [7:0]    r_lb1 [IMG_W];
    logic [7:0]    r_win [9];

    logic [7:0]    r_res;
    logic          r_res_valid;
    logic          r_frame_done;
    logic          r_last_win;

    logic          w_accept;
    logic          w_complete;
    logic          w_last_pix;
    logic          w_mac_done;
    logic [7:0]    w_tap1;
    logic [7:0]    w_tap2;

    assign w_accept   = pix_valid & pix_ready;
    assign w_complete = w_accept && (r_row >= ROW_TWO) && (r_col >= COL_TWO);
    assign w_last_pix = (r_row == ROW_LAST) && (r_col == COL_LAST);
    assign w_mac_done = (r_state == S_COMPUTE) && (r_cnt == CNT_LAST);
    assign w_tap1     = r_lb0[r_col];
    assign w_tap2     = r_lb1[r_col];

    // Next-state and ready: ready only when idle or on the MAC's final (add-zero) step.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        pix_ready   = 1'b0;
        case (r_state)
            S_FILL: begin
                pix_ready = 1'b1;
                if (w_complete) begin
                    w_state_nxt = S_COMPUTE;
                    w_cnt_nxt   = 4'd0;
                end
            end
            S_COMPUTE: begin
                if (r_cnt == CNT_LAST) begin
                    pix_ready = 1'b1;
                    if (w_complete) begin
                        w_cnt_nxt = 4'd0;
                    end else begin
                        w_state_nxt = S_FILL;
                        w_cnt_nxt   = CNT_IDLE;
                    end
                end else begin
                    w_cnt_nxt = r_cnt + 4'd1;
                end
            end
            default: begin
                w_state_nxt = S_FILL;
                w_cnt_nxt   = CNT_IDLE;
            end
        endcase
    end

    // State register and MAC step counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_FILL;
            r_cnt   <= CNT_IDLE;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // Raster position tracking with wrap at end of row and end of frame.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_col <= '0;
            r_row <= '0;
        end else if (w_accept) begin
            if (r_col == COL_LAST) begin
                r_col <= '0;
                r_row <= (r_row == ROW_LAST) ? '0 : r_row + 1'b1;
            end else begin
                r_col <= r_col + 1'b1;
            end
        end
    end

    // Line buffer RAM; never cleared since every entry is written before it is read.
    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_lb1[r_col] <= r_lb0[r_col];
            r_lb0[r_col] <= pix_in;
        end
    end

    // Window shift: new column {tap2,tap1,pix} enters on the right on each accept.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 9; i++) r_win[i] <= '0;
        end else if (w_accept) begin
            r_win[0] <= r_win[1];
            r_win[1] <= r_win[2];
            r_win[2] <= w_tap2;
            r_win[3] <= r_win[4];
            r_win[4] <= r_win[5];
            r_win[5] <= w_tap1;
            r_win[6] <= r_win[7];
            r_win[7] <= r_win[8];
            r_win[8] <= pix_in;
        end
    end

    // Result capture at the end of step 9; flags whether this window closes the frame.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_res        <= '0;
            r_res_valid  <= 1'b0;
            r_frame_done <= 1'b0;
            r_last_win   <= 1'b0;
        end else begin
            r_res_valid  <= w_mac_done;
            r_frame_done <= w_mac_done & r_last_win;
            if (w_mac_done) r_res <= ans;
            if (w_complete) r_last_win <= w_last_pix;
        end
    end

    assign win0       = r_win[0];
    assign win1       = r_win[1];
    assign win2       = r_win[2];
    assign win3       = r_win[3];
    assign win4       = r_win[4];
    assign win5       = r_win[5];
    assign win6       = r_win[6];
    assign win7       = r_win[7];
    assign win8       = r_win[8];
    assign cnt        = r_cnt;
    assign res_data   = r_res;
    assign res_valid  = r_res_valid;
    assign frame_done = r_frame_done;

endmodule

// File: tb/tb_conv3x3_window_gen.sv
// Bench for conv3x3_window_gen on a 4x4 image with a behavioural MAC attached.
`timescale 1ns/1ps
module tb_conv3x3_window_gen;

    localparam int W    = 4;
    localparam int H    = 4;
    localparam int NPIX = W * H;
    localparam int NWIN = (W - 2) * (H - 2);

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [7:0] pix_in = '0;
    logic       pix_valid = 1'b0;
    logic       pix_ready;
    logic [7:0] win0, win1, win2, win3, win4, win5, win6, win7, win8;
    logic [3:0] cnt;
    logic [7:0] ans;
    logic [7:0] res_data;
    logic       res_valid;
    logic       frame_done;

    conv3x3_window_gen #(.IMG_W(W), .IMG_H(H)) dut (
        .clk(clk), .rst(rst), .pix_in(pix_in), .pix_valid(pix_valid), .pix_ready(pix_ready),
        .win0(win0), .win1(win1), .win2(win2), .win3(win3), .win4(win4),
        .win5(win5), .win6(win6), .win7(win7), .win8(win8),
        .cnt(cnt), .ans(ans), .res_data(res_data), .res_valid(res_valid), .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;
    int cyc    = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- behavioural MAC and reference ----------------
    int  wt [9];
    int  img [NPIX];
    int  acc = 0;
    bit  force_ans = 1'b0;
    logic [7:0] wv [9];
    assign wv[0] = win0; assign wv[1] = win1; assign wv[2] = win2;
    assign wv[3] = win3; assign wv[4] = win4; assign wv[5] = win5;
    assign wv[6] = win6; assign wv[7] = win7; assign wv[8] = win8;

    function automatic logic [7:0] sat8(input int v);
        if (v > 127) return 8'd127;
        if (v < -128) return 8'h80;
        return v[7:0];
    endfunction

    function automatic int prod(input int i);
        return int'($signed(wv[i])) * wt[i];
    endfunction

    always @(posedge clk) begin
        if (cnt == 4'd0) acc <= prod(0);
        else if (cnt <= 4'd8) acc <= acc + prod(int'(cnt));
    end
    assign ans = force_ans ? 8'h5A : sat8(acc);

    function automatic logic [71:0] exp_win(input int k);
        logic [71:0] w;
        int kr, kc, p;
        kr = k / (W - 2);
        kc = k % (W - 2);
        w = '0;
        for (int i = 0; i < 9; i++) begin
            p = img[(kr + i / 3) * W + kc + i % 3];
            w[71 - 8 * i -: 8] = p[7:0];
        end
        return w;
    endfunction

    function automatic logic [7:0] exp_res(input int k);
        int kr, kc, s;
        if (force_ans) return 8'h5A;
        kr = k / (W - 2);
        kc = k % (W - 2);
        s = 0;
        for (int i = 0; i < 9; i++) s += img[(kr + i / 3) * W + kc + i % 3] * wt[i];
        return sat8(s);
    endfunction

    function automatic logic [71:0] packwin();
        return {win0, win1, win2, win3, win4, win5, win6, win7, win8};
    endfunction

    // ---------------- monitor ----------------
    logic [71:0] win_q [$];
    logic [8:0]  res_q [$];
    int          res_cyc_q [$];
    int          acc_cyc_q [$];
    int          rdy_low = 0, rdy_runs = 0, n_fd_stray = 0, n_unstable = 0, n_badcnt = 0;
    bit          prev_low = 1'b0;
    logic [71:0] cur_win = '0;

    always @(negedge clk) begin
        if (!rst) begin
            if (cnt == 4'd0) begin
                cur_win = packwin();
                win_q.push_back(cur_win);
            end else if (cnt <= 4'd8 && packwin() !== cur_win) begin
                n_unstable++;
            end
            if (res_valid) begin
                res_q.push_back({frame_done, res_data});
                res_cyc_q.push_back(cyc);
            end else if (frame_done) begin
                n_fd_stray++;
            end
            if (!pix_ready) begin
                rdy_low++;
                if (!prev_low) rdy_runs++;
            end
            prev_low = !pix_ready;
            if (cnt > 4'd9 && cnt != 4'd15) n_badcnt++;
            if (pix_ready !== (cnt == 4'd15 || cnt == 4'd9)) n_badcnt++;
        end
    end

    // ---------------- helpers ----------------
    task automatic chk(input string tag, input logic [71:0] obs, input logic [71:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic clear_mon();
        win_q.delete(); res_q.delete(); res_cyc_q.delete(); acc_cyc_q.delete();
        rdy_low = 0; rdy_runs = 0; n_fd_stray = 0; n_unstable = 0; n_badcnt = 0;
        prev_low = 1'b0;
    endtask

    task automatic rand_weights();
        for (int i = 0; i < 9; i++) wt[i] = int'($urandom_range(0, 255)) - 128;
    endtask

    // Offer n pixels (img repeated per frame); stop early after 'abort_after' completing accepts.
    task automatic send(input int n, input bit rnd, input int abort_after);
        int i = 0, budget = 0, ncomp = 0, pos, p;
        bit stop = 1'b0;
        while (i < n && budget < 2000 && !stop) begin
            @(negedge clk);
            budget++;
            p = img[i % NPIX];
            pix_in = p[7:0];
            pix_valid = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            if (pix_valid && pix_ready) begin
                pos = i % NPIX;
                if (pos / W >= 2 && pos % W >= 2) begin
                    acc_cyc_q.push_back(cyc);
                    ncomp++;
                end
                i++;
                if (abort_after > 0 && ncomp == abort_after) stop = 1'b1;
            end
        end
        chk("send_within_budget", budget < 2000, 1'b1);
        @(negedge clk);
        pix_valid = 1'b0;
    endtask

    task automatic verify(input int nwin);
        chk("window_count", win_q.size(), nwin);
        chk("result_count", res_q.size(), nwin);
        for (int k = 0; k < nwin; k++) begin
            if (k < win_q.size()) chk("window_taps", win_q[k], exp_win(k % NWIN));
            if (k < res_q.size()) begin
                chk("res_data", res_q[k][7:0], exp_res(k % NWIN));
                chk("frame_done", res_q[k][8], (k % NWIN) == NWIN - 1);
            end
            if (k < res_cyc_q.size() && k < acc_cyc_q.size())
                chk("result_latency", res_cyc_q[k] - acc_cyc_q[k], 11);
        end
        chk("ready_low_cycles", rdy_low, 9 * nwin);
        chk("ready_low_runs", rdy_runs, nwin);
        chk("frame_done_stray", n_fd_stray, 0);
        chk("window_stable", n_unstable, 0);
        chk("ready_vs_cnt", n_badcnt, 0);
        chk("idle_cnt", cnt, 4'd15);
    endtask

    task automatic chk_reset_vals();
        chk("rst_cnt", cnt, 4'd15);
        chk("rst_win", packwin(), 72'd0);
        chk("rst_res_data", res_data, 8'd0);
        chk("rst_res_valid", res_valid, 1'b0);
        chk("rst_frame_done", frame_done, 1'b0);
        chk("rst_pix_ready", pix_ready, 1'b1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- directed sequence ----------------
    initial begin
        for (int i = 0; i < NPIX; i++) img[i] = i + 1;
        rand_weights();

        // reset values
        rst = 1'b1;
        repeat (3) @(negedge clk);
        chk_reset_vals();
        rst = 1'b0;
        @(negedge clk);
        clear_mon();

        // pixels 1..16, valid always: window taps, results, frame_done, latency
        send(NPIX, 1'b0, 0);
        repeat (25) @(negedge clk);
        verify(NWIN);
        clear_mon();

        // forced MAC answer 0x5A
        force_ans = 1'b1;
        send(NPIX, 1'b0, 0);
        repeat (25) @(negedge clk);
        verify(NWIN);
        force_ans = 1'b0;
        clear_mon();

        // random pix_valid gaps, same frame
        rand_weights();
        send(NPIX, 1'b1, 0);
        repeat (25) @(negedge clk);
        verify(NWIN);
        clear_mon();

        // reset during window 2 at cnt==5
        send(NPIX, 1'b0, 2);
        for (int b = 0; b < 20 && cnt != 4'd5; b++) @(negedge clk);
        chk("reach_cnt5", cnt, 4'd5);
        chk("pre_reset_results", res_q.size(), 1);
        rst = 1'b1;
        #1;
        chk_reset_vals();
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (15) @(negedge clk);
        chk("no_result_after_reset", res_q.size(), 1);
        chk_reset_vals();
        clear_mon();
        send(NPIX, 1'b0, 0);
        repeat (25) @(negedge clk);
        verify(NWIN);
        clear_mon();

        // two back-to-back frames, all 127 pixels and weights -> saturated 127
        for (int i = 0; i < NPIX; i++) img[i] = 127;
        for (int i = 0; i < 9; i++) wt[i] = 127;
        send(2 * NPIX, 1'b0, 0);
        repeat (25) @(negedge clk);
        verify(2 * NWIN);
        clear_mon();

        // random signed pixels and weights, random gaps, two frames
        for (int i = 0; i < NPIX; i++) img[i] = int'($urandom_range(0, 255)) - 128;
        rand_weights();
        send(2 * NPIX, 1'b1, 0);
        repeat (25) @(negedge clk);
        verify(2 * NWIN);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
